nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-precision adder that adds two WIDTH-bit operands one nibble per clock through a single 4-bit ripple-carry adder. Each nibble's carry-out is registered and fed back as the next nibble's carry-in. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides. This trades latency for area when wide additions are needed but only one 4-bit adder is wanted.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.
- busy  output  1  high in ADD state.

## Operation
- NIB = WIDTH/4, the number of nibble steps.
- States are IDLE, ADD and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b and c_in into operand shift registers, clear nibble index and result register, go to ADD.
- ADD:
  - Each cycle, low nibble of A/B plus the registered carry go into the 4-bit adder.
  - The 4-bit sum is shifted into the result register from the MSB end.
  - The adder's carry-out is registered; A/B shift right by 4; index increments.
  - After step NIB-1: c_out ← final carry, compute ovf, go to DONE.
- ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), using the latched operand MSBs.
- DONE:
  - out_valid=1; sum, c_out and ovf are held stable.
  - On out_valid & out_ready: go to IDLE.
  - sum, c_out and ovf keep their values until the next acceptance clears them.
- in_ready is 0 in ADD and DONE. in_valid is ignored there; the source must hold its operands.
- A new transaction is not accepted in the same cycle as result hand-off. It is accepted at the earliest one cycle later, in IDLE.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, ovf=0, index=0, carry register=0.
  - Reset overrides every other event, including mid-ADD and in DONE with out_ready=1.
  - An aborted transaction never produces out_valid.
- Latency: operands accepted at edge E0 → out_valid high after edge E0+NIB (4 cycles for WIDTH=16).
- Throughput: one transaction per NIB+2 cycles with out_ready held high.
- busy is high exactly NIB cycles per transaction.
- Index width is clog2(NIB), with a minimum of 1 bit. For WIDTH=4, ADD lasts a single cycle.
- Back-pressure:
  - DONE persists indefinitely while out_ready=0.
  - Outputs do not change while out_valid=1.

## Structure
- Shared package/header holds:
  - the state encoding: IDLE=2'd0, ADD=2'd1, DONE=2'd2;
  - the constant NIBBLE_W=4.
- Exactly one instance of the team's existing RCA_4bit full-adder chain is instantiated as the datapath. Port order is (s, c_out, a, b, c_in).
- The FSM, operand shift registers, result register and index counter are local to this module. No other sub-module.

## Test plan
WIDTH=16 throughout.
- a=16'h00FF, b=16'h0001, c_in=0 → sum=16'h0100, c_out=0, ovf=0; out_valid exactly 4 cycles after acceptance; busy high 4 cycles.
- a=16'hFFFF, b=16'h0001, c_in=0 → sum=16'h0000, c_out=1, ovf=0. Carry must ripple through all four nibble steps.
- Two's-complement overflow:
  - a=16'h7FFF, b=16'h0001 → sum=16'h8000, ovf=1, c_out=0.
  - a=16'h8000, b=16'h8000 → sum=16'h0000, c_out=1, ovf=1.
  - a=0, b=0, c_in=1 → sum=16'h0001.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles after out_valid → sum/c_out/ovf stable, in_ready=0.
  - Toggle in_valid with new operands during this window → ignored.
  - Raise out_ready → IDLE next cycle; next transaction accepted correctly.
- Reset mid-operation:
  - Drive rst_n=0 during the 2nd ADD cycle → next cycle all outputs zero, in_ready=1, no out_valid ever for the aborted operands.
  - New transaction after release completes correctly.
- Random regression: 1000 random a/b/c_in with random out_ready stalls → every result matches a reference sum, c_out and ovf; exactly one out_valid hand-off per acceptance.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int unsigned NibbleW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/RCA_4bit.sv
// 4-bit ripple-carry adder built from a chain of full adders.
module RCA_4bit
    import nibble_serial_adder_pkg::*;
(
    output logic [NibbleW-1:0] s,
    output logic               c_out,
    input  logic [NibbleW-1:0] a,
    input  logic [NibbleW-1:0] b,
    input  logic               c_in
);

    logic [NibbleW:0] c;

    always_comb begin
        c[0] = c_in;
        s    = '0;
        for (int i = 0; i < NibbleW; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = c[NibbleW];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder: one nibble per clock through a single 4-bit ripple adder,
// with valid/ready handshakes on operand and result sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned Nib  = WIDTH / NibbleW;
    localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Nib - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;

    logic [NibbleW-1:0] nib_s;
    logic               nib_c;
    logic [WIDTH-1:0]   sum_shift;

    RCA_4bit u_rca (
        .s     (nib_s),
        .c_out (nib_c),
        .a     (a_q[NibbleW-1:0]),
        .b     (b_q[NibbleW-1:0]),
        .c_in  (carry_q)
    );

    // Each new nibble enters at the MSB end so that after Nib steps it lands in place.
    if (WIDTH == NibbleW) begin : g_single
        assign sum_shift = nib_s;
    end else begin : g_multi
        assign sum_shift = {nib_s, sum_q[WIDTH-1:NibbleW]};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                busy    = 1'b1;
                sum_d   = sum_shift;
                carry_d = nib_c;
                a_d     = a_q >> NibbleW;
                b_d     = b_q >> NibbleW;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    // Low nibble of the shift registers now holds the operand MSBs.
                    c_out_d = nib_c;
                    ovf_d   = (a_q[NibbleW-1] == b_q[NibbleW-1]) &&
                              (nib_s[NibbleW-1] != a_q[NibbleW-1]);
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vectors plus a
// queue-based reference model checked on every cycle out_valid is high.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         c_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, c_out, ovf, busy;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;
    int n_acc = 0;
    int n_hand = 0;
    bit src_done = 1'b0;
    logic [W+1:0] expq[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference result packed as {ovf, c_out, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {o, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("out_valid_without_accept", 32'(out_valid), 32'd0);
                end else begin
                    chk("model_result", {14'd0, ovf, c_out, sum}, {14'd0, expq[0]});
                    if (out_ready) begin
                        void'(expq.pop_front());
                        n_hand++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, c_in));
                n_acc++;
            end
        end
    end

    task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input int stall);
        int cyc;
        int bcnt;
        bit ok;
        @(posedge clk); #1;
        a = ta; b = tb2; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            cyc++;
            if (busy) bcnt++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("latency", cyc, 32'd4);
        chk("busy_cycles", bcnt, 32'd4);
        chk("sum", 32'(sum), 32'(es));
        chk("c_out", 32'(c_out), 32'(ec));
        chk("ovf", 32'(ovf), 32'(eo));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            in_valid = i[0];
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", {14'd0, ovf, c_out, sum}, {14'd0, eo, ec, es});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_handoff", {30'd0, out_valid, in_ready}, 32'd1);
        chk("sum_kept", 32'(sum), 32'(es));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_acc;
        int base_hand;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {25'd0, in_ready, out_valid, busy, c_out, ovf, 2'd0},
            {25'd0, 1'b1, 6'd0});
        chk("reset_sum", 32'(sum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        txn(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        txn(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        txn(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 10);
        txn(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        txn(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);

        // Abort in the second ADD cycle.
        @(posedge clk); #1;
        a = 16'hABCD; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {27'd0, in_ready, out_valid, busy, c_out, ovf},
            {27'd0, 5'b10000});
        chk("abort_sum", 32'(sum), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_out_after_abort", 32'(out_valid), 32'd0);
        end
        txn(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);

        base_acc  = n_acc;
        base_hand = n_hand;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    bit ok;
                    @(posedge clk); #1;
                    a = 16'($urandom);
                    b = 16'($urandom);
                    c_in = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    ok = 1'b0;
                    for (int j = 0; j < 200; j++) begin
                        @(negedge clk);
                        if (in_ready) begin ok = 1'b1; break; end
                    end
                    if (!ok) chk("rand_accept_timeout", 32'(in_ready), 32'd1);
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
                src_done = 1'b1;
            end
            begin
                int g;
                g = 0;
                while ((!src_done || expq.size() != 0) && g < 60000) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    g++;
                end
                out_ready = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("rand_accepts", n_acc - base_acc, 32'd1000);
        chk("handoffs_match_accepts", n_hand - base_hand, n_acc - base_acc);
        chk("queue_drained", expq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
